// File: rtl/router_pkt_sink.sv
// Destination-side reader for one router output FIFO: drains a packet, streams its
// payload, checks the trailing XOR parity byte and aborts on a prolonged FIFO stall.
module router_pkt_sink #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              sink_en,
   input  logic              empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              read_enb,
   output logic              byte_valid,
   output logic [DATA_W-1:0] byte_out,
   output logic [1:0]        pkt_addr,
   output logic [5:0]        pkt_len,
   output logic              pkt_done,
   output logic              parity_err,
   output logic              timeout_err,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_count
);

   localparam int            TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t            state;
   logic [6:0]        need;
   logic [6:0]        issued;
   logic [6:0]        recvd;
   logic [TW-1:0]     stall_cnt;
   logic              vld_p1;
   logic [DATA_W-1:0] parity_acc;

   logic in_body;
   logic want;
   logic take;
   logic payload_hit;
   logic parity_hit;
   logic stall_hit;

   // Read issue and consume decode; soft_reset masks every strobe in its cycle.
   always_comb begin
      in_body     = (state == BODY);
      want        = in_body && (issued < need);
      read_enb    = resetn && !soft_reset && !empty &&
                    (((state == IDLE) && sink_en) || want);
      take        = in_body && vld_p1 && !soft_reset;
      payload_hit = take && (recvd < {1'b0, pkt_len});
      parity_hit  = take && (recvd == {1'b0, pkt_len});
      stall_hit   = want && empty && !soft_reset && (stall_cnt == STALL_LAST);
   end

   assign byte_valid  = payload_hit;
   assign byte_out    = payload_hit ? fifo_data : '0;
   assign pkt_done    = parity_hit;
   assign parity_err  = parity_hit && (parity_acc != fifo_data);
   assign timeout_err = stall_hit;
   assign busy        = (state != IDLE);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         need       <= '0;
         issued     <= '0;
         recvd      <= '0;
         stall_cnt  <= '0;
         vld_p1     <= 1'b0;
         parity_acc <= '0;
         pkt_addr   <= '0;
         pkt_len    <= '0;
         pkt_count  <= '0;
      end else if (soft_reset) begin
         state      <= IDLE;
         need       <= '0;
         issued     <= '0;
         recvd      <= '0;
         stall_cnt  <= '0;
         vld_p1     <= 1'b0;
         parity_acc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (read_enb) state <= HDR;
            end
            HDR: begin
               pkt_len    <= fifo_data[7:2];
               pkt_addr   <= fifo_data[1:0];
               parity_acc <= fifo_data;
               need       <= 7'(fifo_data[7:2]) + 7'd1;
               issued     <= '0;
               recvd      <= '0;
               stall_cnt  <= '0;
               vld_p1     <= 1'b0;
               state      <= BODY;
            end
            BODY: begin
               // Stage boundary: a read this cycle returns its byte next cycle.
               vld_p1 <= read_enb;
               if (read_enb) begin
                  issued    <= issued + 7'd1;
                  stall_cnt <= '0;
               end else if (want && empty) begin
                  stall_cnt <= stall_cnt + TW'(1);
               end
               if (payload_hit) begin
                  parity_acc <= parity_acc ^ fifo_data;
                  recvd      <= recvd + 7'd1;
               end
               if (parity_hit) begin
                  if (!parity_err) pkt_count <= pkt_count + CNT_W'(1);
                  vld_p1 <= 1'b0;
                  state  <= IDLE;
               end
               if (stall_hit) begin
                  vld_p1    <= 1'b0;
                  stall_cnt <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
